banco_registros_param: RTL and testbench
========================================

// Module: banco_registros_param
// PURPOSE
//   Parametrised, clocked register bank for the datapath. It is the next
//   generation of the combinational register bank, with these additions:
//   - synchronous write with async reset
//   - read-during-write bypass
//   - a multi-cycle bulk-clear engine with busy/error status
//   Sits between instruction decode (RA1/RA2/WA) and the ALU operand muxes.
// PARAMETERS
//   WIDTH   32  data word width in bits
//   DEPTH   32  number of registers; must be >= 2; AW = $clog2(DEPTH) (localparam)
//   BYPASS  1   1: a read of the address being written returns Din same cycle; 0: returns old value
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   Din       in   WIDTH  write data
//   RA1       in   AW     read address, port 1
//   RA2       in   AW     read address, port 2
//   WA        in   AW     write address
//   RegWrite  in   1      write enable, sampled on clk rise
//   Clear     in   1      bulk-clear request, sampled on clk rise
//   DR1       out  WIDTH  read data, port 1 (combinational)
//   DR2       out  WIDTH  read data, port 2 (combinational)
//   Busy      out  1      registered; 1 while the clear engine runs
//   WrErr     out  1      registered one-cycle pulse: a write was dropped
// BEHAVIOUR
//   - Reset (rst_n=0, async): all DEPTH registers = 0; FSM = IDLE; clear counter = 0;
//     Busy = 0; WrErr = 0; DR1 = DR2 = 0 (bypass suppressed while in reset).
//   - FSM states: IDLE, CLEAR.
//     - IDLE -> CLEAR when Clear=1 at a clk edge; counter <= 0.
//     - In CLEAR, each edge writes BR[cnt] <= 0 and cnt <= cnt+1.
//     - The edge that clears BR[DEPTH-1] returns the FSM to IDLE.
//     - Busy is 1 for exactly DEPTH cycles.
//     - Clear asserted during CLEAR is ignored; it does not restart the engine.
//   - Write: in IDLE, RegWrite=1 at an edge -> BR[WA] <= Din.
//     - In CLEAR, RegWrite=1 is dropped and WrErr=1 on the next cycle; otherwise WrErr=0.
//   - Clear and RegWrite in the same IDLE cycle: the write commits on that edge,
//     and the clear sweep later zeroes it.
//   - Read: DRn = BR[RAn], with no latency.
//     - While Busy=1, DR1 = DR2 = 0 regardless of array contents.
//     - If BYPASS=1, state is IDLE, RegWrite=1 and RAn==WA, then DRn = Din.
//   - Address >= DEPTH (non-power-of-2 DEPTH only):
//     - reads return 0;
//     - writes are dropped with no WrErr.
//   - Reset mid-clear: immediately IDLE, all registers 0, Busy=0; no partial state survives.
//   - Counter width is AW+1 so DEPTH = 2**AW terminates without wrap ambiguity.
// CONFIGURATION
//   BR_ZERO_REG_EN defined:
//     - register 0 is hardwired 0; reads of address 0 return 0;
//     - writes to WA=0 are silently discarded (no WrErr);
//     - bypass never applies to WA=0.
//   BR_ZERO_REG_EN undefined:
//     - register 0 is an ordinary storage register.
// TESTING
//   1. Reset check: hold rst_n=0, RA1=5, RA2=31 -> DR1=0, DR2=0, Busy=0, WrErr=0.
//   2. Write/read: RegWrite=1, WA=3, Din=32'd1859, edge; then RA1=3 -> DR1=1859.
//      Also RA2=4 -> DR2=0.
//   3. Bypass, same cycle: RegWrite=1, WA=7, Din=32'd917, RA1=7, before the edge:
//      - BYPASS=1 -> DR1=917;
//      - BYPASS=0 -> DR1=old value (0).
//   4. Clear sweep:
//      - setup: load R1=2682 and R20=1; pulse Clear for one cycle;
//      - Busy=1 for exactly 32 cycles, and DR1=0 throughout;
//      - after Busy falls, RA1=1 -> 0 and RA2=20 -> 0.
//   5. Write during clear: at cycle 5 of Busy drive RegWrite=1, WA=2, Din=2583:
//      - WrErr=1 for one cycle;
//      - after Busy falls, RA1=2 -> 0.
//   6. Zero register, with BR_ZERO_REG_EN defined:
//      - write WA=0, Din=516; then RA1=0 -> DR1=0, and WrErr stays 0;
//      - with the macro undefined, DR1=516.
//      Also assert rst_n=0 at cycle 10 of a clear -> Busy=0 immediately.

Source files
------------

// File: rtl/banco_registros_param.sv
// Clocked register bank: two combinational read ports, one synchronous write port and a bulk-clear engine.
// Optional macro BR_ZERO_REG_EN hardwires register 0 to zero.
module banco_registros_param #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         Din,
  input  logic [$clog2(DEPTH)-1:0] RA1,
  input  logic [$clog2(DEPTH)-1:0] RA2,
  input  logic [$clog2(DEPTH)-1:0] WA,
  input  logic                     RegWrite,
  input  logic                     Clear,
  output logic [WIDTH-1:0]         DR1,
  output logic [WIDTH-1:0]         DR2,
  output logic                     Busy,
  output logic                     WrErr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

`ifdef BR_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [0:0]       state;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] br [DEPTH];
  logic             busy_q;
  logic             wrerr_q;
  logic             wa_ok;
  logic             wr_en;

  // Out-of-range and hardwired-zero targets are discarded without raising WrErr.
  assign wa_ok = ({1'b0, WA} < DEPTH_C) && !(ZERO_REG && (WA == '0));
  assign wr_en = (state == S_IDLE) && RegWrite && wa_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      wrerr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) br[i] <= '0;
    end else begin
      wrerr_q <= (state == S_CLEAR) && RegWrite;
      case (state)
        S_IDLE: begin
          if (wr_en) br[WA] <= Din;
          if (Clear) begin
            state  <= S_CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        default: begin
          // One register per cycle; Clear requests here are ignored.
          br[cnt[AW-1:0]] <= '0;
          cnt             <= cnt + ONE_C;
          if (cnt == LAST_C) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
      endcase
    end
  end

  function automatic logic [WIDTH-1:0] rd_port(input logic [AW-1:0] ra);
    logic [WIDTH-1:0] d;
    d = '0;
    if (!rst_n || busy_q) begin
      d = '0;
    end else if (({1'b0, ra} >= DEPTH_C) || (ZERO_REG && (ra == '0))) begin
      d = '0;
    end else if ((BYPASS != 0) && wr_en && (ra == WA)) begin
      d = Din;
    end else begin
      d = br[ra];
    end
    return d;
  endfunction

  always_comb begin
    DR1 = rd_port(RA1);
    DR2 = rd_port(RA2);
  end

  assign Busy  = busy_q;
  assign WrErr = wrerr_q;

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench for banco_registros_param: expected values queued at drive time, popped at sample time.
module tb_banco_registros_param;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int BYPASS = 1;
  localparam int AW     = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] Din;
  logic [AW-1:0]    RA1, RA2, WA;
  logic             RegWrite, Clear;
  logic [WIDTH-1:0] DR1, DR2;
  logic             Busy, WrErr;

  logic [31:0] sb[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n;

  banco_registros_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS)) dut (
    .clk(clk), .rst_n(rst_n), .Din(Din), .RA1(RA1), .RA2(RA2), .WA(WA),
    .RegWrite(RegWrite), .Clear(Clear), .DR1(DR1), .DR2(DR2), .Busy(Busy), .WrErr(WrErr)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    RegWrite = 1'b1; WA = a; Din = d;
    tick();
    RegWrite = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; Din = 32'd123; RA1 = 5'd5; RA2 = 5'd31; WA = 5'd5;
    RegWrite = 1'b1; Clear = 1'b0;
    #12;
    // Reset: outputs zero even with a bypass-eligible write pending
    push_exp(0); chk("reset_dr1", DR1);
    push_exp(0); chk("reset_dr2", DR2);
    push_exp(0); chk("reset_busy", 32'(Busy));
    push_exp(0); chk("reset_wrerr", 32'(WrErr));
    RegWrite = 1'b0;
    tick();
    rst_n = 1'b1;
    #2;

    // Basic write/read
    wr(5'd3, 32'd1859);
    RA1 = 5'd3; RA2 = 5'd4; #1;
    push_exp(1859); chk("wr_rd_dr1", DR1);
    push_exp(0);    chk("wr_rd_dr2", DR2);
    push_exp(0);    chk("wr_wrerr", 32'(WrErr));

    // Same-cycle bypass
    RegWrite = 1'b1; WA = 5'd7; Din = 32'd917; RA1 = 5'd7; RA2 = 5'd3; #1;
    push_exp(BYPASS != 0 ? 917 : 0); chk("bypass_dr1", DR1);
    push_exp(1859);                  chk("bypass_other_dr2", DR2);
    tick();
    RegWrite = 1'b0; #1;
    push_exp(917); chk("after_bypass_dr1", DR1);

    // Clear sweep with a re-request mid-sweep that must not restart it
    wr(5'd1, 32'd2682);
    wr(5'd20, 32'd1);
    RA1 = 5'd1; RA2 = 5'd20; #1;
    push_exp(2682); chk("preload_r1", DR1);
    push_exp(1);    chk("preload_r20", DR2);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      push_exp(0); chk("clear_dr1_zero", DR1);
      if (n == 10) Clear = 1'b1;
      tick();
      Clear = 1'b0;
    end
    push_exp(DEPTH); chk("clear_busy_cycles", n);
    #1;
    push_exp(0); chk("cleared_r1", DR1);
    push_exp(0); chk("cleared_r20", DR2);
    RA1 = 5'd3; #1;
    push_exp(0); chk("cleared_r3", DR1);

    // Write during clear is dropped and flagged
    RA1 = 5'd2;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      if (n == 5) begin
        RegWrite = 1'b1; WA = 5'd2; Din = 32'd2583; #1;
        push_exp(0); chk("clear_no_bypass", DR1);
      end
      if (n == 6) begin
        push_exp(1); chk("wrerr_pulse", 32'(WrErr));
      end
      if (n == 7) begin
        push_exp(0); chk("wrerr_one_cycle", 32'(WrErr));
      end
      tick();
      RegWrite = 1'b0;
    end
    push_exp(DEPTH); chk("clear2_busy_cycles", n);
    push_exp(0); chk("dropped_write_r2", DR1);

    // Register 0
    wr(5'd0, 32'd516);
    RA1 = 5'd0; #1;
`ifdef BR_ZERO_REG_EN
    push_exp(0);
`else
    push_exp(516);
`endif
    chk("reg0_read", DR1);
    push_exp(0); chk("reg0_wrerr", 32'(WrErr));

    // Reset in the middle of a sweep
    wr(5'd25, 32'd444);
    RA1 = 5'd25; #1;
    push_exp(444); chk("preload_r25", DR1);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    repeat (9) tick();
    push_exp(1); chk("midclear_busy", 32'(Busy));
    rst_n = 1'b0; #1;
    push_exp(0); chk("midreset_busy", 32'(Busy));
    push_exp(0); chk("midreset_dr1", DR1);
    tick();
    rst_n = 1'b1;
    tick();
    push_exp(0); chk("post_reset_busy", 32'(Busy));
    push_exp(0); chk("post_reset_r25", DR1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
